// File: rtl/dm_unit_if.sv
// M-stage memory access bundle: controller decode, address/data from the M slice,
// and the registered load result handed to W.
interface dm_unit_if;
  logic        memwrite;
  logic [1:0]  writedm_op;
  logic [2:0]  readdm_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc_m;
  logic [31:0] rdata_w;

  // No handshake: the pipeline presents one instruction per cycle and
  // rdata_w is always valid one cycle later; nothing can apply backpressure.
  modport master (
    output memwrite, writedm_op, readdm_op, addr, wdata, pc_m,
    input  rdata_w
  );

  modport slave (
    input  memwrite, writedm_op, readdm_op, addr, wdata, pc_m,
    output rdata_w
  );
endinterface

// File: rtl/dm_unit.sv
// P6 M-stage data memory: byte-lane merged stores into a word array and
// sign/zero-extended loads registered into the M/W slice.
module dm_unit #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input logic   clk,
  input logic   reset,
  dm_unit_if.slave bus
);

  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_BYTE = 2'b01;
  localparam logic [1:0] ST_HALF = 2'b10;

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic [31:0]   mem [WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   cur_word;
  logic [31:0]   merged;
  logic [31:0]   load_val;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic          we;
  logic [31:0]   rdata_q;

  // Upper address bits are dropped on purpose, so the array aliases.
  assign idx      = bus.addr[AW+1:2];
  assign cur_word = mem[idx];
  assign we       = bus.memwrite && (bus.writedm_op != 2'b11);

  always_comb begin
    sel_byte = cur_word[7:0];
    case (bus.addr[1:0])
      2'b00: sel_byte = cur_word[7:0];
      2'b01: sel_byte = cur_word[15:8];
      2'b10: sel_byte = cur_word[23:16];
      2'b11: sel_byte = cur_word[31:24];
      default: sel_byte = cur_word[7:0];
    endcase
    sel_half = bus.addr[1] ? cur_word[31:16] : cur_word[15:0];
  end

  always_comb begin
    merged = cur_word;
    case (bus.writedm_op)
      ST_WORD: merged = bus.wdata;
      ST_BYTE: begin
        case (bus.addr[1:0])
          2'b00: merged[7:0]   = bus.wdata[7:0];
          2'b01: merged[15:8]  = bus.wdata[7:0];
          2'b10: merged[23:16] = bus.wdata[7:0];
          2'b11: merged[31:24] = bus.wdata[7:0];
          default: merged = cur_word;
        endcase
      end
      ST_HALF: begin
        if (bus.addr[1]) merged[31:16] = bus.wdata[15:0];
        else             merged[15:0]  = bus.wdata[15:0];
      end
      default: merged = cur_word;
    endcase
  end

  always_comb begin
    load_val = cur_word;
    case (bus.readdm_op)
      LD_LB:   load_val = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  load_val = {24'h0, sel_byte};
      LD_LH:   load_val = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  load_val = {16'h0, sel_half};
      default: load_val = cur_word;
    endcase
  end

  // Capture reads the pre-store word; the store lands in the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      rdata_q <= load_val;
      if (we) mem[idx] <= merged;
    end
  end

  assign bus.rdata_w = rdata_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && we)
      $display("@%h: *%h <= %h", bus.pc_m, {bus.addr[31:2], 2'b00}, merged);
  end
`endif

endmodule

// File: tb/tb_dm_unit.sv
// Bench for dm_unit: directed load/store scenarios plus random traffic checked
// against a byte-addressed memory model.
module tb_dm_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  dm_unit_if bus ();

  dm_unit u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [7:0] mb [0:16383];
  logic [31:0] exp_q [$];

  function automatic int base_of(input logic [31:0] a);
    return int'(a[13:2]) * 4;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16384; i++) mb[i] = 8'h00;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] rop);
    int b;
    int h;
    logic [7:0]  byt;
    logic [15:0] hw;
    b   = base_of(a);
    h   = b + (a[1] ? 2 : 0);
    byt = mb[b + int'(a[1:0])];
    hw  = {mb[h+1], mb[h]};
    case (rop)
      3'd1: return {{24{byt[7]}}, byt};
      3'd2: return {24'h0, byt};
      3'd3: return {{16{hw[15]}}, hw};
      3'd4: return {16'h0, hw};
      default: return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endcase
  endfunction

  task automatic model_store(input logic mw, input logic [1:0] wop,
                             input logic [31:0] a, input logic [31:0] wd);
    int b;
    b = base_of(a);
    if (mw) begin
      case (wop)
        2'd0: begin
          mb[b] = wd[7:0]; mb[b+1] = wd[15:8]; mb[b+2] = wd[23:16]; mb[b+3] = wd[31:24];
        end
        2'd1: mb[b + int'(a[1:0])] = wd[7:0];
        2'd2: begin
          mb[b + (a[1] ? 2 : 0)]     = wd[7:0];
          mb[b + (a[1] ? 2 : 0) + 1] = wd[15:8];
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // One M-stage instruction per call; returns rdata_w as seen in its W cycle.
  task automatic step(input logic mw, input logic [1:0] wop, input logic [2:0] rop,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bus.memwrite   = mw;
    bus.writedm_op = wop;
    bus.readdm_op  = rop;
    bus.addr       = a;
    bus.wdata      = wd;
    bus.pc_m       = 32'h0000_3000 + $urandom_range(0, 255) * 4;
    @(posedge clk);
    #1;
    rd = bus.rdata_w;
    model_store(mw, wop, a, wd);
  endtask

  task automatic idle_inputs();
    bus.memwrite   = 1'b0;
    bus.writedm_op = 2'b11;
    bus.readdm_op  = 3'b000;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.pc_m       = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    n_checks++;
    if (bus.rdata_w !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_initial: rdata_w=%h expected=%h", bus.rdata_w, 32'h0);
    end
    step(1'b1, 2'b00, 3'b000, 32'h10, 32'hDEAD_BEEF, rd);
    step(1'b0, 2'b00, 3'b000, 32'h10, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL reset_prewrite: rdata_w=%h expected=%h", rd, 32'hDEAD_BEEF);
    end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (bus.rdata_w !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: rdata_w=%h expected=%h", bus.rdata_w, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'b00, 3'b000, 32'h10, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cleared_word: rdata_w=%h expected=%h", rd, 32'h0);
    end
  endtask

  task automatic test_word_byte();
    logic [31:0] rd;
    step(1'b1, 2'b00, 3'b000, 32'h10, 32'h1234_5678, rd);
    step(1'b1, 2'b01, 3'b000, 32'h11, 32'hFFFF_FFAB, rd);
    step(1'b0, 2'b00, 3'b000, 32'h10, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h1234_AB78) begin
      n_fail++;
      $display("FAIL sb_merge: rdata_w=%h expected=%h", rd, 32'h1234_AB78);
    end
    step(1'b0, 2'b00, 3'b001, 32'h11, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hFFFF_FFAB) begin
      n_fail++;
      $display("FAIL lb_sign: rdata_w=%h expected=%h", rd, 32'hFFFF_FFAB);
    end
    step(1'b0, 2'b00, 3'b010, 32'h11, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_00AB) begin
      n_fail++;
      $display("FAIL lbu_zero: rdata_w=%h expected=%h", rd, 32'h0000_00AB);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd;
    step(1'b1, 2'b10, 3'b000, 32'h12, 32'h0000_8001, rd);
    step(1'b0, 2'b00, 3'b000, 32'h10, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h8001_AB78) begin
      n_fail++;
      $display("FAIL sh_merge: rdata_w=%h expected=%h", rd, 32'h8001_AB78);
    end
    step(1'b0, 2'b00, 3'b011, 32'h12, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hFFFF_8001) begin
      n_fail++;
      $display("FAIL lh_sign: rdata_w=%h expected=%h", rd, 32'hFFFF_8001);
    end
    step(1'b0, 2'b00, 3'b100, 32'h13, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_8001) begin
      n_fail++;
      $display("FAIL lhu_odd_addr: rdata_w=%h expected=%h", rd, 32'h0000_8001);
    end
    step(1'b0, 2'b00, 3'b011, 32'h10, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hFFFF_AB78) begin
      n_fail++;
      $display("FAIL lh_low_half: rdata_w=%h expected=%h", rd, 32'hFFFF_AB78);
    end
  endtask

  task automatic test_nonstore();
    logic [31:0] rd;
    step(1'b1, 2'b11, 3'b000, 32'h10, 32'h5555_5555, rd);
    step(1'b0, 2'b00, 3'b000, 32'h10, 32'hAAAA_AAAA, rd);
    step(1'b0, 2'b00, 3'b000, 32'h10, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h8001_AB78) begin
      n_fail++;
      $display("FAIL nonstore_unchanged: rdata_w=%h expected=%h", rd, 32'h8001_AB78);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd;
    step(1'b1, 2'b00, 3'b000, 32'h4000, 32'hCAFE_BABE, rd);
    step(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hCAFE_BABE) begin
      n_fail++;
      $display("FAIL alias_lw0: rdata_w=%h expected=%h", rd, 32'hCAFE_BABE);
    end
    step(1'b0, 2'b00, 3'b000, 32'h3, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hCAFE_BABE) begin
      n_fail++;
      $display("FAIL alias_lw3: rdata_w=%h expected=%h", rd, 32'hCAFE_BABE);
    end
    step(1'b0, 2'b00, 3'b000, 32'hFFFF_C010, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h8001_AB78) begin
      n_fail++;
      $display("FAIL alias_high_bits: rdata_w=%h expected=%h", rd, 32'h8001_AB78);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    step(1'b1, 2'b00, 3'b000, 32'h20, 32'h0000_007F, rd);
    step(1'b0, 2'b00, 3'b001, 32'h20, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_007F) begin
      n_fail++;
      $display("FAIL b2b_lb_pos: rdata_w=%h expected=%h", rd, 32'h0000_007F);
    end
    step(1'b1, 2'b01, 3'b000, 32'h20, 32'h0000_0080, rd);
    step(1'b0, 2'b00, 3'b001, 32'h20, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL b2b_lb_neg: rdata_w=%h expected=%h", rd, 32'hFFFF_FF80);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    logic        mw;
    logic [1:0]  wop;
    logic [2:0]  rop;
    logic [31:0] wd;
    for (int n = 0; n < 400; n++) begin
      a        = $urandom;
      a[13:2]  = 12'($urandom_range(0, 15));
      mw       = 1'($urandom_range(0, 1));
      wop      = 2'($urandom_range(0, 3));
      rop      = 3'($urandom_range(0, 7));
      wd       = $urandom;
      exp_q.push_back(model_load(a, rop));
      step(mw, wop, rop, a, wd, rd);
      n_checks++;
      if (rd !== exp_q[0]) begin
        n_fail++;
        $display("FAIL random_%0d: addr=%h rop=%0d rdata_w=%h expected=%h",
                 n, a, rop, rd, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    // Sweep every word touched so committed random stores are all read back.
    for (int w = 0; w < 16; w++) begin
      a = 32'(w * 4);
      exp_q.push_back(model_load(a, 3'b000));
      step(1'b0, 2'b00, 3'b000, a, 32'h0, rd);
      n_checks++;
      if (rd !== exp_q[0]) begin
        n_fail++;
        $display("FAIL sweep_word_%0d: rdata_w=%h expected=%h", w, rd, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    test_reset_entry();
    test_word_byte();
    test_half();
    test_nonstore();
    test_alias();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Reset-state check runs while reset is still held, then releases it.
  task automatic test_reset_entry();
    n_checks++;
    if (bus.rdata_w !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held: rdata_w=%h expected=%h", bus.rdata_w, 32'h0);
    end
    rst_n = 1'b1;
    test_reset();
  endtask

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- M-stage data memory and load/store datapath of the P6 pipeline.
- Consumes the M-stage controller decode: `memwrite`, `writedm_op`, `readdm_op`.
- Performs byte-lane-merged stores into a word-organised array and sign/zero-extended loads.
- Registers load data as the M/W pipeline slice feeding W-stage write-back.

Parameters:
- WORDS, 4096, number of 32-bit words in the array.
- AW, 12, word-index width; equals log2(WORDS).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- memwrite  input  1  store enable from M-stage controller.
- writedm_op  input  2  store width: 00 word, 01 byte, 10 half, 11 no store.
- readdm_op  input  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others treated as lw.
- addr  input  32  byte address (ALU result in M).
- wdata  input  32  store data (forwarded rt value in M).
- pc_m  input  32  PC of the M-stage instruction, used only for the write log.
- rdata_w  output  32  extended load data, registered; valid in W stage.

Behaviour:
- Reset:
  - Asserting reset low immediately clears rdata_w to 0 and every array word to 0, independent of clk.
  - While reset is low, no writes occur and no log line is printed.
  - Deassertion takes effect at the next rising edge.
- Addressing:
  - Word index is addr[AW+1:2].
  - addr[31:AW+2] is ignored, so addresses alias modulo WORDS*4; 0x4000 maps to word 0 with defaults.
  - Byte lanes are little-endian: addr[1:0]=00 selects bits 7:0, 11 selects bits 31:24.
  - Half lanes: addr[1]=0 selects bits 15:0, addr[1]=1 selects bits 31:16; addr[0] is ignored.
  - For word access addr[1:0] is ignored.
- Store commit, on rising clk when reset is high and memwrite=1:
  - writedm_op=00: word replaced by wdata.
  - writedm_op=01: selected byte lane replaced by wdata[7:0]; other lanes unchanged.
  - writedm_op=10: selected half lane replaced by wdata[15:0]; other half unchanged.
  - writedm_op=11: no write.
  - memwrite=0: no write, regardless of writedm_op.
- Write log: on every committed store, $display "@%h: *%h <= %h" with:
  - pc_m,
  - {addr[31:2],2'b00},
  - the full merged 32-bit word after the store.
- Load path:
  - Array word is read combinationally at the current index.
  - It is extended per readdm_op:
    - lb: sign-extend selected byte.
    - lbu: zero-extend selected byte.
    - lh: sign-extend selected half.
    - lhu: zero-extend selected half.
    - lw: full word.
  - Result is captured into rdata_w on every rising edge, regardless of instruction type.
  - Load latency is 1 cycle: the value is visible in rdata_w in the cycle the instruction occupies W.
- Read-during-write:
  - A single instruction is in M per cycle, so a store and a load never coincide.
  - Same-cycle capture returns the pre-store word.
  - A load in cycle N+1 after a store in cycle N returns the post-store data; no bypass is required.
- No stall or flush inputs. M/W bubbles arrive as `memwrite=0` with don't-care `readdm_op`; rdata_w still updates and W ignores it.

Test Plan:
- Reset: drive reset low mid-cycle after writes → rdata_w=0 immediately. After release, lw at 0x10 → rdata_w=0x00000000.
- Word and byte store:
  - sw 0x12345678 @0x10, then sb wdata=0xFFFFFFAB @0x11 → log "@pc: *00000010 <= 1234ab78".
  - lb @0x11 → 0xFFFFFFAB; lbu @0x11 → 0x000000AB.
- Half store:
  - sh wdata=0x00008001 @0x12 on word 0x1234AB78 → word 0x8001AB78.
  - lh @0x12 → 0xFFFF8001; lhu @0x13 → 0x00008001 (addr[0] ignored).
- Non-store cases: memwrite=1 with writedm_op=11, and memwrite=0 with writedm_op=00 → no log line, word unchanged.
- Aliasing: sw 0xCAFEBABE @0x4000 → log address 0x00004000. lw @0x0 → 0xCAFEBABE. lw @0x3 → 0xCAFEBABE.
- Back-to-back: sw 0x0000007F @0x20 in cycle N, lb @0x20 in cycle N+1 → rdata_w=0x0000007F in cycle N+2. Then sb 0x80 @0x20 followed by lb @0x20 → 0xFFFFFF80.
